// File: rtl/washer_pkg.sv
// Shared definitions for the washer cycle controller.
//   - phase codes reported on the phase output
//   - FSM state enumeration, whose encodings equal the phase codes
//   - clamp_cycles(): limits the requested wash/rinse pair count to 1..max
package washer_pkg;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_WASH  = 3'd2;
    localparam logic [2:0] PH_RINSE = 3'd3;
    localparam logic [2:0] PH_SPIN  = 3'd4;
    localparam logic [2:0] PH_PAUSE = 3'd5;
    localparam logic [2:0] PH_DONE  = 3'd6;

    // State encodings equal the phase codes, so the phase output is just the state register.
    typedef enum logic [2:0] {
        S_IDLE  = PH_IDLE,
        S_FILL  = PH_FILL,
        S_WASH  = PH_WASH,
        S_RINSE = PH_RINSE,
        S_SPIN  = PH_SPIN,
        S_PAUSE = PH_PAUSE,
        S_DONE  = PH_DONE
    } state_e;

    // A request of zero still runs one pair.
    // A request beyond the machine's capability runs the maximum.
    function automatic int clamp_cycles(input int req, input int max_c);
        if (req < 1) begin
            return 1;
        end else if (req > max_c) begin
            return max_c;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/washer_cycle_controller_phase_timer.sv
// Shared phase timer: a prescaler that produces one-second ticks, plus a seconds down-counter.
// Ports:
//   clock, rst_n   clock, asynchronous active-low reset
//   load           loads load_val into the seconds counter and clears the prescaler
//                  (load wins over enable)
//   load_val       seconds value to load
//   enable         advance the prescaler this cycle
//   sec_remaining  current seconds count (registered)
//   expire         combinational; high on the prescaler wrap that would take the count from 1 to 0
module phase_timer #(
    parameter int CLK_PER_SEC = 16000000,
    parameter int SEC_W       = 10
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load,
    input  logic [SEC_W-1:0] load_val,
    input  logic             enable,
    output logic [SEC_W-1:0] sec_remaining,
    output logic             expire
);

    localparam int              PRE_W    = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             wrap;

    assign wrap          = enable && (presc_q == PRE_LAST);
    assign expire        = wrap && (sec_q == SEC_W'(1));
    assign sec_remaining = sec_q;

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        if (load) begin
            presc_d = '0;
            sec_d   = load_val;
        end else if (enable) begin
            if (wrap) begin
                presc_d = '0;
                sec_d   = sec_q - SEC_W'(1);
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end

endmodule

// File: rtl/washer_cycle_controller.sv
// Washing-machine sequencer.
// Runs FILL, then (WASH, RINSE) x N, then SPIN, then DONE, all paced by one shared phase timer.
// Ports:
//   clock, rst_n   clock, asynchronous active-low reset
//   coin_in        starts a run from IDLE or DONE (level)
//   wash_cycles    requested wash/rinse pairs; clamped and latched at start
//   pause_req      freezes the active phase while high
//   abort          returns to IDLE from any non-IDLE state
//   phase          current phase code (washer_pkg PH_*)
//   cycle_idx      0-based index of the current wash/rinse pair
//   sec_remaining  seconds left in the current phase (0 in IDLE/DONE)
//   busy           high in FILL/WASH/RINSE/SPIN/PAUSE
//   wash_done      high in DONE
//   phase_done     one-cycle pulse after each phase expiry
module washer_cycle_controller
    import washer_pkg::*;
#(
    parameter int CLK_PER_SEC = 16000000,
    parameter int SEC_W       = 10,
    parameter int MAX_CYCLES  = 4,
    parameter int CYC_W       = 3,
    parameter int FILL_SEC    = 120,
    parameter int WASH_SEC    = 300,
    parameter int RINSE_SEC   = 120,
    parameter int SPIN_SEC    = 60
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             coin_in,
    input  logic [CYC_W-1:0] wash_cycles,
    input  logic             pause_req,
    input  logic             abort,
    output logic [2:0]       phase,
    output logic [CYC_W-1:0] cycle_idx,
    output logic [SEC_W-1:0] sec_remaining,
    output logic             busy,
    output logic             wash_done,
    output logic             phase_done
);

    localparam logic [SEC_W-1:0] FILL_L  = SEC_W'(FILL_SEC);
    localparam logic [SEC_W-1:0] WASH_L  = SEC_W'(WASH_SEC);
    localparam logic [SEC_W-1:0] RINSE_L = SEC_W'(RINSE_SEC);
    localparam logic [SEC_W-1:0] SPIN_L  = SEC_W'(SPIN_SEC);

    state_e           state_q, state_d;
    state_e           saved_q, saved_d;      // phase to resume after PAUSE
    logic [CYC_W-1:0] cycle_idx_q, cycle_idx_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;    // latched pair count for this run
    logic             busy_q, busy_d;
    logic             wash_done_q, wash_done_d;
    logic             phase_done_q, phase_done_d;

    logic             tmr_load;
    logic [SEC_W-1:0] tmr_load_val;
    logic             tmr_enable;
    logic             tmr_expire;

    // Where the timed phase goes on expiry
    state_e           run_phase;
    state_e           adv_state;
    logic [SEC_W-1:0] adv_load_val;
    logic [CYC_W-1:0] adv_idx;
    logic             active;

    phase_timer #(
        .CLK_PER_SEC (CLK_PER_SEC),
        .SEC_W       (SEC_W)
    ) u_timer (
        .clock         (clock),
        .rst_n         (rst_n),
        .load          (tmr_load),
        .load_val      (tmr_load_val),
        .enable        (tmr_enable),
        .sec_remaining (sec_remaining),
        .expire        (tmr_expire)
    );

    assign active = (state_q == S_FILL) || (state_q == S_WASH) ||
                    (state_q == S_RINSE) || (state_q == S_SPIN);

    // The timer runs in active phases, and also in the PAUSE cycle where pause_req has
    // already dropped. The pause-entry cycle makes no progress, so the resume cycle must.
    // This makes the added latency equal the number of cycles spent in PAUSE.
    // Abort and a live pause_req always freeze the timer, so a coinciding expiry is
    // deferred rather than lost.
    assign tmr_enable = (active || (state_q == S_PAUSE)) && !pause_req && !abort;

    assign run_phase = (state_q == S_PAUSE) ? saved_q : state_q;

    // Successor of the timed phase on expiry
    always_comb begin
        adv_state    = S_IDLE;
        adv_load_val = '0;
        adv_idx      = cycle_idx_q;
        case (run_phase)
            S_FILL: begin
                adv_state    = S_WASH;
                adv_load_val = WASH_L;
            end
            S_WASH: begin
                adv_state    = S_RINSE;
                adv_load_val = RINSE_L;
            end
            S_RINSE: begin
                if (int'(cycle_idx_q) + 1 < int'(cycles_q)) begin
                    adv_state    = S_WASH;
                    adv_load_val = WASH_L;
                    adv_idx      = cycle_idx_q + CYC_W'(1);
                end else begin
                    adv_state    = S_SPIN;
                    adv_load_val = SPIN_L;
                end
            end
            S_SPIN: begin
                adv_state    = S_DONE;
                adv_load_val = '0;
            end
            default: begin
                adv_state    = S_IDLE;
                adv_load_val = '0;
            end
        endcase
    end

    // Next state and timer control. Priority: abort > pause_req > expiry > coin_in.
    always_comb begin
        state_d      = state_q;
        saved_d      = saved_q;
        cycle_idx_d  = cycle_idx_q;
        cycles_d     = cycles_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    // Abort from IDLE has nothing to terminate; it also blocks a coinciding coin.
                    state_d      = S_IDLE;
                    cycle_idx_d  = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = '0;
                end else if (coin_in) begin
                    state_d      = S_FILL;
                    cycles_d     = CYC_W'(clamp_cycles(int'(wash_cycles), MAX_CYCLES));
                    cycle_idx_d  = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = FILL_L;
                end
            end
            S_FILL, S_WASH, S_RINSE, S_SPIN: begin
                if (abort) begin
                    state_d      = S_IDLE;
                    cycle_idx_d  = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = '0;
                end else if (pause_req) begin
                    saved_d = state_q;
                    state_d = S_PAUSE;
                end else if (tmr_expire) begin
                    state_d      = adv_state;
                    cycle_idx_d  = adv_idx;
                    tmr_load     = 1'b1;
                    tmr_load_val = adv_load_val;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_d      = S_IDLE;
                    cycle_idx_d  = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = '0;
                end else if (!pause_req) begin
                    if (tmr_expire) begin
                        // A deferred expiry fires on the resume cycle.
                        state_d      = adv_state;
                        cycle_idx_d  = adv_idx;
                        tmr_load     = 1'b1;
                        tmr_load_val = adv_load_val;
                    end else begin
                        state_d = saved_q;
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                cycle_idx_d  = '0;
                tmr_load     = 1'b1;
                tmr_load_val = '0;
            end
        endcase

        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        wash_done_d  = (state_d == S_DONE);
        // Expiry only happens with the timer enabled, which already excludes abort/pause.
        phase_done_d = tmr_expire;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            saved_q      <= S_IDLE;
            cycle_idx_q  <= '0;
            cycles_q     <= CYC_W'(1);
            busy_q       <= 1'b0;
            wash_done_q  <= 1'b0;
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            cycle_idx_q  <= cycle_idx_d;
            cycles_q     <= cycles_d;
            busy_q       <= busy_d;
            wash_done_q  <= wash_done_d;
            phase_done_q <= phase_done_d;
        end
    end

    assign phase      = state_q;
    assign cycle_idx  = cycle_idx_q;
    assign busy       = busy_q;
    assign wash_done  = wash_done_q;
    assign phase_done = phase_done_q;

endmodule

// File: tb/tb_washer_cycle_controller.sv
// Directed testbench for washer_cycle_controller.
// Configuration: CLK_PER_SEC=4, FILL=2s, WASH=3s, RINSE=2s, SPIN=1s, MAX_CYCLES=4.
// A phase therefore lasts FILL 8, WASH 12, RINSE 8 and SPIN 4 cycles.
module tb_washer_cycle_controller;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       coin_in;
    logic [2:0] wash_cycles;
    logic       pause_req;
    logic       abort;
    logic [2:0] phase;
    logic [2:0] cycle_idx;
    logic [9:0] sec_remaining;
    logic       busy;
    logic       wash_done;
    logic       phase_done;

    int n_err = 0;
    int n_chk = 0;
    int cnt_ph[8];
    int n_pd;
    int elapsed;
    int idx_trace[$];

    washer_cycle_controller #(
        .CLK_PER_SEC (4),
        .SEC_W       (10),
        .MAX_CYCLES  (4),
        .CYC_W       (3),
        .FILL_SEC    (2),
        .WASH_SEC    (3),
        .RINSE_SEC   (2),
        .SPIN_SEC    (1)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .coin_in       (coin_in),
        .wash_cycles   (wash_cycles),
        .pause_req     (pause_req),
        .abort         (abort),
        .phase         (phase),
        .cycle_idx     (cycle_idx),
        .sec_remaining (sec_remaining),
        .busy          (busy),
        .wash_done     (wash_done),
        .phase_done    (phase_done)
    );

    always #5 clock = ~clock;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_run(input logic [2:0] wc);
        wash_cycles = wc;
        coin_in     = 1'b1;
        tick();
        coin_in     = 1'b0;
    endtask

    // Step until wash_done or the cycle limit.
    // Records cycles per phase, phase_done pulses and the pair index at each WASH entry.
    task automatic profile(input int limit);
        logic [2:0] prev_ph;
        prev_ph = 3'd7;
        for (int i = 0; i < 8; i++) cnt_ph[i] = 0;
        n_pd    = 0;
        elapsed = 0;
        idx_trace.delete();
        while (wash_done !== 1'b1 && elapsed < limit) begin
            cnt_ph[int'(phase)]++;
            if (phase == 3'd2 && prev_ph != 3'd2) idx_trace.push_back(int'(cycle_idx));
            prev_ph = phase;
            tick();
            elapsed++;
            if (phase_done === 1'b1) n_pd++;
        end
        $display("run: elapsed=%0d fill=%0d wash=%0d rinse=%0d spin=%0d pause=%0d pulses=%0d",
                 elapsed, cnt_ph[1], cnt_ph[2], cnt_ph[3], cnt_ph[4], cnt_ph[5], n_pd);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; coin_in = 1'b0; wash_cycles = 3'd1; pause_req = 1'b0; abort = 1'b0;
        repeat (3) tick();
        n_chk++; if (phase !== 3'd0) begin n_err++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        n_chk++; if (cycle_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d expected 0", cycle_idx); end
        n_chk++; if (sec_remaining !== 10'd0) begin n_err++; $display("FAIL reset_sec: got %0d expected 0", sec_remaining); end
        n_chk++; if ({busy, wash_done, phase_done} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {busy, wash_done, phase_done}); end
        rst_n = 1'b1;
        tick();
        n_chk++; if (phase !== 3'd0) begin n_err++; $display("FAIL idle_hold: got %0d expected 0", phase); end
        $display("test_reset done");
    endtask

    task automatic test_single_cycle();
        start_run(3'd1);
        n_chk++; if (phase !== 3'd1) begin n_err++; $display("FAIL start_phase: got %0d expected 1", phase); end
        n_chk++; if (sec_remaining !== 10'd2) begin n_err++; $display("FAIL start_sec: got %0d expected 2", sec_remaining); end
        n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b expected 1", busy); end
        profile(200);
        n_chk++; if (cnt_ph[1] !== 8) begin n_err++; $display("FAIL single_fill: got %0d expected 8", cnt_ph[1]); end
        n_chk++; if (cnt_ph[2] !== 12) begin n_err++; $display("FAIL single_wash: got %0d expected 12", cnt_ph[2]); end
        n_chk++; if (cnt_ph[3] !== 8) begin n_err++; $display("FAIL single_rinse: got %0d expected 8", cnt_ph[3]); end
        n_chk++; if (cnt_ph[4] !== 4) begin n_err++; $display("FAIL single_spin: got %0d expected 4", cnt_ph[4]); end
        n_chk++; if (elapsed !== 32) begin n_err++; $display("FAIL single_total: got %0d expected 32", elapsed); end
        n_chk++; if (n_pd !== 4) begin n_err++; $display("FAIL single_pulses: got %0d expected 4", n_pd); end
        n_chk++; if (phase !== 3'd6 || busy !== 1'b0 || sec_remaining !== 10'd0) begin
            n_err++; $display("FAIL done_state: got phase=%0d busy=%b sec=%0d expected 6/0/0", phase, busy, sec_remaining);
        end
    endtask

    task automatic test_three_cycles();
        start_run(3'd3);   // from DONE
        n_chk++; if (wash_done !== 1'b0 || phase !== 3'd1) begin
            n_err++; $display("FAIL restart: got phase=%0d done=%b expected 1/0", phase, wash_done);
        end
        profile(300);
        n_chk++; if (elapsed !== 72) begin n_err++; $display("FAIL three_total: got %0d expected 72", elapsed); end
        n_chk++; if (cnt_ph[2] !== 36 || cnt_ph[3] !== 24) begin
            n_err++; $display("FAIL three_phases: got wash=%0d rinse=%0d expected 36/24", cnt_ph[2], cnt_ph[3]);
        end
        n_chk++; if (idx_trace.size() !== 3) begin
            n_err++; $display("FAIL three_idx_count: got %0d expected 3", idx_trace.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++; if (idx_trace[i] !== i) begin n_err++; $display("FAIL three_idx%0d: got %0d expected %0d", i, idx_trace[i], i); end
            end
        end
        n_chk++; if (n_pd !== 8) begin n_err++; $display("FAIL three_pulses: got %0d expected 8", n_pd); end
    endtask

    task automatic test_pause();
        start_run(3'd1);
        repeat (12) tick();   // 4 cycles into WASH
        n_chk++; if (phase !== 3'd2 || sec_remaining !== 10'd2) begin
            n_err++; $display("FAIL pre_pause: got phase=%0d sec=%0d expected 2/2", phase, sec_remaining);
        end
        pause_req = 1'b1;
        tick();
        n_chk++; if (phase !== 3'd5 || sec_remaining !== 10'd2 || busy !== 1'b1) begin
            n_err++; $display("FAIL pause_enter: got phase=%0d sec=%0d busy=%b expected 5/2/1", phase, sec_remaining, busy);
        end
        repeat (9) tick();
        n_chk++; if (phase !== 3'd5 || sec_remaining !== 10'd2) begin
            n_err++; $display("FAIL pause_frozen: got phase=%0d sec=%0d expected 5/2", phase, sec_remaining);
        end
        pause_req = 1'b0;
        profile(200);
        n_chk++; if (22 + elapsed !== 42) begin n_err++; $display("FAIL pause_total: got %0d expected 42", 22 + elapsed); end

        // pause_req on the FILL expiry cycle defers the expiry
        start_run(3'd1);
        repeat (7) tick();
        pause_req = 1'b1;
        tick();
        n_chk++; if (phase !== 3'd5 || sec_remaining !== 10'd1 || phase_done !== 1'b0) begin
            n_err++; $display("FAIL defer_pause: got phase=%0d sec=%0d pd=%b expected 5/1/0", phase, sec_remaining, phase_done);
        end
        pause_req = 1'b0;
        tick();
        n_chk++; if (phase !== 3'd2 || sec_remaining !== 10'd3 || phase_done !== 1'b1) begin
            n_err++; $display("FAIL defer_expire: got phase=%0d sec=%0d pd=%b expected 2/3/1", phase, sec_remaining, phase_done);
        end
        profile(200);
        n_chk++; if (elapsed !== 24) begin n_err++; $display("FAIL defer_total: got %0d expected 24", elapsed); end
    endtask

    task automatic test_abort();
        start_run(3'd2);
        repeat (23) tick();
        n_chk++; if (phase !== 3'd3) begin n_err++; $display("FAIL abort_pre: got %0d expected 3", phase); end
        abort = 1'b1;
        tick();
        n_chk++; if (phase !== 3'd0 || busy !== 1'b0 || wash_done !== 1'b0 || sec_remaining !== 10'd0 || cycle_idx !== 3'd0) begin
            n_err++; $display("FAIL abort_rinse: got phase=%0d busy=%b done=%b sec=%0d idx=%0d expected 0/0/0/0/0",
                              phase, busy, wash_done, sec_remaining, cycle_idx);
        end
        coin_in = 1'b1;
        tick();
        n_chk++; if (phase !== 3'd0) begin n_err++; $display("FAIL abort_over_coin: got %0d expected 0", phase); end
        abort = 1'b0;
        tick();
        coin_in = 1'b0;
        n_chk++; if (phase !== 3'd1) begin n_err++; $display("FAIL start_after_abort: got %0d expected 1", phase); end
        profile(300);
        n_chk++; if (elapsed !== 52) begin n_err++; $display("FAIL two_total: got %0d expected 52", elapsed); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++; if (wash_done !== 1'b0 || phase !== 3'd0) begin
            n_err++; $display("FAIL abort_done: got done=%b phase=%0d expected 0/0", wash_done, phase);
        end
    endtask

    task automatic test_clamp();
        start_run(3'd0);
        profile(200);
        n_chk++; if (elapsed !== 32 || cnt_ph[2] !== 12) begin
            n_err++; $display("FAIL clamp_zero: got total=%0d wash=%0d expected 32/12", elapsed, cnt_ph[2]);
        end
        start_run(3'd7);
        // Held coin and a changed request must both be ignored during the run.
        coin_in     = 1'b1;
        wash_cycles = 3'd1;
        profile(300);
        coin_in = 1'b0;
        n_chk++; if (elapsed !== 92) begin n_err++; $display("FAIL clamp_seven: got %0d expected 92", elapsed); end
        n_chk++; if (cnt_ph[2] !== 48 || cnt_ph[3] !== 32) begin
            n_err++; $display("FAIL clamp_phases: got wash=%0d rinse=%0d expected 48/32", cnt_ph[2], cnt_ph[3]);
        end
        n_chk++; if (cnt_ph[1] !== 8) begin n_err++; $display("FAIL coin_busy: got fill=%0d expected 8", cnt_ph[1]); end
    endtask

    task automatic test_reset_mid_run();
        tick();
        start_run(3'd1);
        repeat (29) tick();
        n_chk++; if (phase !== 3'd4) begin n_err++; $display("FAIL pre_reset: got %0d expected 4", phase); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (phase !== 3'd0 || cycle_idx !== 3'd0 || sec_remaining !== 10'd0 || {busy, wash_done, phase_done} !== 3'b000) begin
            n_err++; $display("FAIL async_reset: got phase=%0d idx=%0d sec=%0d flags=%b expected all 0",
                              phase, cycle_idx, sec_remaining, {busy, wash_done, phase_done});
        end
        #3 rst_n = 1'b1;
        tick();
        n_chk++; if (phase !== 3'd0) begin n_err++; $display("FAIL post_reset: got %0d expected 0", phase); end
        start_run(3'd1);
        profile(200);
        n_chk++; if (elapsed !== 32) begin n_err++; $display("FAIL post_reset_run: got %0d expected 32", elapsed); end
        coin_in = 1'b1;
        tick();
        coin_in = 1'b0;
        n_chk++; if (phase !== 3'd1 || wash_done !== 1'b0 || sec_remaining !== 10'd2) begin
            n_err++; $display("FAIL done_restart: got phase=%0d done=%b sec=%0d expected 1/0/2", phase, wash_done, sec_remaining);
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_three_cycles();
        test_pause();
        test_abort();
        test_clamp();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
